// File: rtl/vregfile_scalar_reader.sv
// Scalar regfile read-port front end: request handshake, 1-cycle RAM latency,
// write-port collision bypass and a 2-entry skid buffer on the response side.
module vregfile_scalar_reader #(
    parameter int WIDTH       = 32,
    parameter int NUMREGS     = 32,
    parameter int LOG2NUMREGS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [LOG2NUMREGS-1:0] req_reg,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [LOG2NUMREGS-1:0] rsp_reg,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [LOG2NUMREGS-1:0] a_reg,
    output logic                   a_en,
    input  logic [WIDTH-1:0]       a_readdataout,
    input  logic [LOG2NUMREGS-1:0] c_reg,
    input  logic [WIDTH-1:0]       c_writedatain,
    input  logic                   c_we
);

    localparam int EW = LOG2NUMREGS + WIDTH;

    // Indices past NUMREGS simply wrap; nothing to build for that case.
    if (NUMREGS > (1 << LOG2NUMREGS)) begin : g_wide_cfg
    end

    logic                   s1_valid;
    logic [LOG2NUMREGS-1:0] s1_reg;
    logic                   s1_zero;
    logic                   s1_hit;
    logic [WIDTH-1:0]       s1_byp;
    logic [WIDTH-1:0]       s1_data;

    logic [EW-1:0]          fifo_q [2];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             count;

    logic                   accept;
    logic                   pop;
    logic                   fifo_nonempty;
    logic                   push_mem;
    logic [2:0]             credit;
    logic [EW-1:0]          head;

    assign accept = req_valid & req_ready;
    assign a_reg  = req_reg;
    assign a_en   = accept;

    always_comb begin
        s1_data = a_readdataout;
        if (s1_zero) begin
            s1_data = '0;
        end else if (s1_hit) begin
            s1_data = s1_byp;
        end
    end

    assign fifo_nonempty = (count != 2'd0);
    assign rsp_valid     = fifo_nonempty | s1_valid;
    assign head          = fifo_nonempty ? fifo_q[rd_ptr] : {s1_reg, s1_data};
    assign {rsp_reg, rsp_data} = rsp_valid ? head : '0;

    assign pop = rsp_valid & rsp_ready;
    // S1 entry consumed straight through when the buffer is empty
    assign push_mem = s1_valid & ~(~fifo_nonempty & pop);
    assign credit   = {1'b0, count} + {2'b0, s1_valid} - {2'b0, pop};
    assign req_ready = ~reset & (credit < 3'd2);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            s1_valid <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            s1_valid <= accept;
            count    <= credit[1:0];
            if (push_mem) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop && fifo_nonempty) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg  <= '0;
            s1_zero <= 1'b0;
            s1_hit  <= 1'b0;
            s1_byp  <= '0;
        end else if (accept) begin
            s1_reg  <= req_reg;
            s1_zero <= (req_reg == '0);
            s1_hit  <= c_we && (c_reg != '0) && (c_reg == req_reg);
            s1_byp  <= c_writedatain;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push_mem) begin
            fifo_q[wr_ptr] <= {s1_reg, s1_data};
        end
    end

endmodule

// File: tb/tb_vregfile_scalar_reader.sv
// Randomized scoreboard bench for vregfile_scalar_reader with a behavioural
// OLD_DATA register-file model driving the read port.
module tb_vregfile_scalar_reader;

    localparam int W = 32;
    localparam int L = 5;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [L-1:0] req_reg;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [L-1:0] rsp_reg;
    logic [W-1:0] rsp_data;
    logic [L-1:0] a_reg;
    logic         a_en;
    logic [W-1:0] a_readdataout;
    logic [L-1:0] c_reg;
    logic [W-1:0] c_writedatain;
    logic         c_we;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]   ram [N];
    logic [L+W-1:0] exp_q [$];

    vregfile_scalar_reader #(.WIDTH(W), .NUMREGS(N), .LOG2NUMREGS(L)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_reg(rsp_reg), .rsp_data(rsp_data),
        .a_reg(a_reg), .a_en(a_en), .a_readdataout(a_readdataout),
        .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we)
    );

    always #5 clk = ~clk;

    // Register file with registered read returning pre-write data.
    always @(posedge clk) begin
        if (a_en) a_readdataout <= ram[a_reg];
        if (c_we) ram[c_reg] <= c_writedatain;
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expected response is the architectural value at the accept cycle.
    always @(negedge clk) begin
        logic [W-1:0] v;
        if (!reset && !flush && req_valid && req_ready) begin
            if (req_reg == 0) v = '0;
            else if (c_we && c_reg == req_reg) v = c_writedatain;
            else v = ram[req_reg];
            exp_q.push_back({req_reg, v});
        end
    end

    always @(negedge clk) begin
        logic [L+W-1:0] e;
        if (!reset && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got reg %0d data %h expected none",
                         rsp_reg, rsp_data);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_reg, rsp_data} !== e) begin
                    errors++;
                    $display("FAIL sb_rsp: got reg %0d data %h expected reg %0d data %h",
                             rsp_reg, rsp_data, e[L+W-1:W], e[W-1:0]);
                end
            end
        end
        if (reset || flush) exp_q.delete();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [L-1:0] r, input logic [W-1:0] d);
        c_we = 1'b1; c_reg = r; c_writedatain = d;
        step();
        c_we = 1'b0;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; c_we = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_reg = '0;
        rsp_ready = 1'b1; c_reg = '0; c_writedatain = '0; c_we = 1'b0;
        step();
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_reg", 32'(rsp_reg), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        step();
        reset = 1'b0;

        for (int i = 1; i < N; i++) wr(i[L-1:0], 32'h100 + i);

        // basic read, 1-cycle latency
        wr(5, 32'h1234);
        req_valid = 1'b1; req_reg = 5; rsp_ready = 1'b1;
        @(negedge clk);
        check("basic_req_ready", 32'(req_ready), 32'd1);
        check("basic_a_en", 32'(a_en), 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("basic_rsp_valid", 32'(rsp_valid), 32'd1);
        check("basic_rsp_reg", 32'(rsp_reg), 32'd5);
        check("basic_rsp_data", rsp_data, 32'h1234);
        check("basic_ready_held", 32'(req_ready), 32'd1);

        // same-cycle collision
        wr(7, 32'h1);
        req_valid = 1'b1; req_reg = 7;
        c_we = 1'b1; c_reg = 7; c_writedatain = 32'hDEADBEEF;
        step();
        idle_inputs();
        @(negedge clk);
        check("collide_data", rsp_data, 32'hDEADBEEF);

        // register 0 always reads zero
        wr(0, 32'hFFFF);
        req_valid = 1'b1; req_reg = 0;
        c_we = 1'b1; c_reg = 0; c_writedatain = 32'h5555;
        step();
        idle_inputs();
        @(negedge clk);
        check("r0_valid", 32'(rsp_valid), 32'd1);
        check("r0_data", rsp_data, 32'd0);

        // backpressure
        wr(1, 32'h11); wr(2, 32'h22); wr(3, 32'h33);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_reg = 1;
        @(negedge clk);
        check("bp_ready_r1", 32'(req_ready), 32'd1);
        step(); req_reg = 2;
        @(negedge clk);
        check("bp_ready_r2", 32'(req_ready), 32'd1);
        step(); req_reg = 3;
        @(negedge clk);
        check("bp_ready_r3", 32'(req_ready), 32'd0);
        check("bp_a_en_r3", 32'(a_en), 32'd0);
        check("bp_head_reg", 32'(rsp_reg), 32'd1);
        step(); rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_release", 32'(req_ready), 32'd1);
        step(); req_valid = 1'b0;
        repeat (4) step();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // write after accept does not alter the read
        wr(9, 32'hA);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_reg = 9;
        step();
        req_valid = 1'b0;
        c_we = 1'b1; c_reg = 9; c_writedatain = 32'hB;
        step();
        c_we = 1'b0;
        step();
        @(negedge clk);
        check("postwr_data", rsp_data, 32'hA);
        rsp_ready = 1'b1;
        step();

        // flush with buffer full (one in FIFO, one in S1)
        wr(4, 32'h4444);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_reg = 1;
        step(); req_reg = 2;
        step();
        req_reg = 6; flush = 1'b1;
        step();
        idle_inputs();
        @(negedge clk);
        check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        check("flush_req_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_reg = 4;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_new_reg", 32'(rsp_reg), 32'd4);
        check("flush_new_data", rsp_data, 32'h4444);
        step();
        @(negedge clk);
        check("flush_no_stale", 32'(rsp_valid), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            req_valid     = ($urandom_range(0, 9) < 7);
            req_reg       = L'($urandom);
            rsp_ready     = ($urandom_range(0, 9) < 7);
            c_we          = $urandom_range(0, 1) == 1;
            c_reg         = ($urandom_range(0, 3) == 0) ? req_reg : L'($urandom);
            c_writedatain = $urandom;
            flush         = ($urandom_range(0, 49) == 0);
        end
        step();
        idle_inputs();
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("final_drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("final_idle", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vregfile_scalar_reader.md
Name: vregfile_scalar_reader

Overview:
- Operand-fetch front end that sits in front of the scalar register file's single read port (a).
- Accepts register read requests on a valid/ready handshake and drives a_reg/a_en.
- Absorbs the RAM's 1-cycle registered read latency and corrects the mixed-port OLD_DATA collision by bypassing from the snooped write port (c).
- Returns read data on a valid/ready response handshake through a 2-entry skid buffer, so it sustains 1 read/cycle under backpressure.

Parameters:
WIDTH, 32, data width of a scalar register
NUMREGS, 32, number of scalar registers
LOG2NUMREGS, 5, register index width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous; discards in-flight read and buffered responses
req_valid  input  1  read request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_reg  input  LOG2NUMREGS  register index to read
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_reg  output  LOG2NUMREGS  index of returned register
rsp_data  output  WIDTH  returned register value
a_reg  output  LOG2NUMREGS  regfile read address
a_en  output  1  regfile read enable
a_readdataout  input  WIDTH  regfile read data, valid the cycle after a_en
c_reg  input  LOG2NUMREGS  snooped regfile write address
c_writedatain  input  WIDTH  snooped regfile write data
c_we  input  1  snooped regfile write enable

Behaviour:
- Clock is clk. Reset is synchronous and active-high, on port reset.
- Reset values: req_ready=0 during the reset cycle, then 1. rsp_valid=0, rsp_reg=0, rsp_data=0. S1 valid=0. FIFO count=0.
- a_reg = req_reg and a_en = req_valid & req_ready, both combinational. The RAM registers the address on the accept edge.
- Stage S1, one cycle after accept, registers: valid, reg, zero flag (req_reg==0), hit flag, bypass data.
  - hit = c_we & (c_reg!=0) & (c_reg==req_reg) in the accept cycle.
  - bypass data = c_writedatain captured in that same cycle.
- Data selection in S1:
  - zero flag set: data = 0. Register 0 always returns 0, regardless of RAM contents or any write to index 0.
  - else hit set: data = bypass data. The RAM returns OLD_DATA on a same-cycle collision, so this substitution is required.
  - else: data = a_readdataout.
- Semantics: a response reflects register state as of the accept cycle, including a write in that same cycle. Writes after the accept cycle do not alter an already-accepted read.
- S1 pushes {reg, data} into a 2-entry FIFO in the same cycle. The FIFO head drives rsp_valid/rsp_reg/rsp_data.
- Latency: with an empty FIFO, a request accepted in cycle N gives rsp_valid=1 in cycle N+1 (head fall-through from S1, combinational mux).
- Credit rule: req_ready = (fifo_count + S1.valid - pop) < 2, where pop = rsp_valid & rsp_ready.
  - Guarantees an S1 push never overflows.
  - Gives 1/cycle throughput when rsp_ready is held high.
- Simultaneous push and pop: count unchanged, ordering preserved (strict FIFO order).
- FIFO full and rsp_ready=0: req_ready=0 and a_en=0. a_readdataout is not needed while stalled, because S1 data is captured in its single valid cycle.
- flush or reset mid-operation:
  - S1 valid and FIFO count clear next edge.
  - A request accepted in the same cycle as flush is dropped.
  - rsp_valid=0 the following cycle.
- Illegal input: req_reg index >= NUMREGS is not checked. The index wraps modulo 2^LOG2NUMREGS.

Test Plan:
- Reset, then RAM holds r5=0x1234. Request r5 with rsp_ready=1 -> rsp_valid next cycle, rsp_reg=5, rsp_data=0x1234. req_ready stays 1.
- Same-cycle collision: request r7 while c_we=1, c_reg=7, c_writedatain=0xDEADBEEF, RAM old r7=0x1 -> rsp_data=0xDEADBEEF.
- Register 0: RAM r0 forced to 0xFFFF, plus a write to r0 in the accept cycle -> rsp_data=0.
- Backpressure: rsp_ready=0, issue r1,r2,r3 back to back -> two accepted, req_ready=0 on the third. Then rsp_ready=1 -> responses r1, r2, r3 in order, no loss or duplication.
- Post-accept write: request r9 (old 0xA), c_we to r9 with 0xB one cycle later, rsp_ready=0 for 3 cycles -> rsp_data=0xA.
- Flush with FIFO full plus S1 valid -> rsp_valid=0 next cycle, req_ready=1. A new r4 request returns correct data with no stale entries.
